// File: rtl/seq_mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM state encoding
// and the sign rule for the final product.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // The magnitudes are multiplied unsigned; the product is negated only when
   // signed operation is active and exactly one operand is negative.
   function automatic logic product_negative(input logic sgn,
                                             input logic a_msb,
                                             input logic b_msb);
      return sgn && (a_msb ^ b_msb);
   endfunction

endpackage

// File: rtl/seq_mult_if.sv
// Operand/result handshake bundle for seq_mult.
interface seq_mult_if #(
   parameter int WIDTH = 16
) ();

   logic                 in_valid;
   logic                 in_ready;
   logic                 signed_mode;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   result;
   logic                 busy;

   modport master (
      output in_valid, signed_mode, a, b, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, signed_mode, a, b, out_ready,
      output in_ready, out_valid, result, busy
   );

endinterface

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier with optional two's-complement mode; one
// multiplier bit per cycle, finishing as soon as the remaining bits are zero.
import seq_mult_pkg::*;

module seq_mult #(
   parameter int WIDTH     = 16,
   parameter int SIGNED_EN = 1
) (
   input logic       clk,
   input logic       rst_n,
   seq_mult_if.slave bus
);

   localparam int               RW    = 2 * WIDTH;
   localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

   // Two's-complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1) as unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic sgn);
      return (sgn && v[WIDTH-1]) ? (~v + ONE_W) : v;
   endfunction

   state_e           state_q, state_d;
   logic [RW-1:0]    acc_q, acc_d;
   logic [RW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic             neg_q, neg_d;
   logic [RW-1:0]    result_q, result_d;
   logic [RW-1:0]    acc_sum;
   logic             sgn;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      neg_d    = neg_q;
      result_d = result_q;
      sgn      = (SIGNED_EN != 0) && bus.signed_mode;
      acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               mcand_d  = {{WIDTH{1'b0}}, magnitude(bus.a, sgn)};
               mplier_d = magnitude(bus.b, sgn);
               neg_d    = product_negative(sgn, bus.a[WIDTH-1], bus.b[WIDTH-1]);
               acc_d    = '0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            // Last iteration when nothing is left above the bit consumed now.
            if ((mplier_q >> 1) == '0) begin
               state_d  = ST_DONE;
               result_d = neg_q ? -acc_sum : acc_sum;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.result    = result_q;

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: vector table, randomized operands against an
// arithmetic reference, plus backpressure and mid-operation reset sequences.
module tb_seq_mult;

   localparam int W      = 16;
   localparam int MAXLAT = 40;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   seq_mult_if #(.WIDTH(W)) if_s ();
   seq_mult_if #(.WIDTH(W)) if_u ();

   seq_mult #(.WIDTH(W), .SIGNED_EN(1)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s));
   seq_mult #(.WIDTH(W), .SIGNED_EN(0)) u_dut_u (.clk(clk), .rst_n(rst_n), .bus(if_u));

   typedef struct {
      string         name;
      bit            u;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic          sm;
      logic [31:0]   exp_res;
      int            exp_lat;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Reference: plain integer multiplication, latency from the multiplier's bit length.
   function automatic void model(input bit u, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic sm, output logic [31:0] pr, output int n);
      bit     sg;
      longint pa, pb, prod, mb;
      sg   = sm && !u;
      pa   = sg ? longint'($signed(av)) : longint'(av);
      pb   = sg ? longint'($signed(bv)) : longint'(bv);
      prod = pa * pb;
      pr   = prod[31:0];
      mb   = (pb < 0) ? -pb : pb;
      n    = 1;
      for (int i = 0; i < W; i++) if (mb[i]) n = i + 1;
   endfunction

   function automatic logic rdy(input bit u);
      return u ? if_u.in_ready : if_s.in_ready;
   endfunction
   function automatic logic ov(input bit u);
      return u ? if_u.out_valid : if_s.out_valid;
   endfunction
   function automatic logic bsy(input bit u);
      return u ? if_u.busy : if_s.busy;
   endfunction
   function automatic logic [31:0] res_of(input bit u);
      return u ? if_u.result : if_s.result;
   endfunction

   task automatic drive_in(input bit u, input logic v, input logic [W-1:0] av,
                           input logic [W-1:0] bv, input logic sm);
      if (u) begin
         if_u.in_valid = v; if_u.a = av; if_u.b = bv; if_u.signed_mode = sm;
      end else begin
         if_s.in_valid = v; if_s.a = av; if_s.b = bv; if_s.signed_mode = sm;
      end
   endtask

   task automatic set_ordy(input bit u, input logic v);
      if (u) if_u.out_ready = v;
      else   if_s.out_ready = v;
   endtask

   // Called #1 after a rising edge with the selected DUT idle.
   task automatic run_op(input bit u, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sm, input int hold,
                         output logic [31:0] res, output int lat);
      chk("in_ready_before_accept", 64'(rdy(u)), 64'(1));
      drive_in(u, 1'b1, av, bv, sm);
      @(posedge clk); #1;
      drive_in(u, 1'b0, W'($urandom), W'($urandom), ~sm);
      chk("busy_after_accept", 64'(bsy(u)), 64'(1));
      chk("in_ready_low_in_run", 64'(rdy(u)), 64'(0));
      lat = 0;
      while (!ov(u) && lat < MAXLAT) begin
         @(posedge clk); #1;
         lat++;
      end
      res = res_of(u);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_out_valid", 64'(ov(u)), 64'(1));
         chk("hold_result", 64'(res_of(u)), 64'(res));
      end
      set_ordy(u, 1'b1);
      @(posedge clk); #1;
      set_ordy(u, 1'b0);
      chk("idle_after_accept_out", 64'(rdy(u)), 64'(1));
      chk("out_valid_cleared", 64'(ov(u)), 64'(0));
      $display("op dut=%s a=%h b=%h sm=%0d result=%h lat=%0d",
               u ? "unsigned_only" : "signed_en", av, bv, sm, res, lat);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if ((if_s.in_ready && if_s.out_valid) || (if_u.in_ready && if_u.out_valid)) begin
            failures++;
            $display("FAIL ready_valid_exclusive actual=1 required=0");
         end
      end
   end

   initial begin
      vec_t        vt[9];
      logic [31:0] res, exp_res;
      int          lat, exp_lat;

      vt[0] = '{"unsigned_basic", 1'b0, 16'd3,    16'd5,    1'b0, 32'h0000000F, 3};
      vt[1] = '{"signed_mixed",   1'b0, 16'hFFFD, 16'd5,    1'b1, 32'hFFFFFFF1, 3};
      vt[2] = '{"b_zero",         1'b0, 16'h1234, 16'h0000, 1'b0, 32'h00000000, 1};
      vt[3] = '{"unsigned_max",   1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 16};
      vt[4] = '{"signed_extreme", 1'b0, 16'h8000, 16'h8000, 1'b1, 32'h40000000, 16};
      vt[5] = '{"signed_off_ext", 1'b1, 16'h8000, 16'h8000, 1'b1, 32'h40000000, 16};
      vt[6] = '{"signed_off_neg", 1'b1, 16'hFFFD, 16'd5,    1'b1, 32'h0004FFF1, 3};
      vt[7] = '{"minus1_squared", 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1};
      vt[8] = '{"neg_multiplier", 1'b0, 16'd5,    16'hFFFD, 1'b1, 32'hFFFFFFF1, 2};

      drive_in(1'b0, 1'b0, '0, '0, 1'b0);
      drive_in(1'b1, 1'b0, '0, '0, 1'b0);
      set_ordy(1'b0, 1'b0);
      set_ordy(1'b1, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  64'(if_s.in_ready),  64'(1));
      chk("rst_out_valid", 64'(if_s.out_valid), 64'(0));
      chk("rst_busy",      64'(if_s.busy),      64'(0));
      chk("rst_result",    64'(if_s.result),    64'(0));
      chk("rst_result_u",  64'(if_u.result),    64'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) begin
         run_op(vt[i].u, vt[i].a, vt[i].b, vt[i].sm, 0, res, lat);
         chk({vt[i].name, "_result"},  64'(res), 64'(vt[i].exp_res));
         chk({vt[i].name, "_latency"}, 64'(lat), 64'(vt[i].exp_lat));
      end

      for (int i = 0; i < 40; i++) begin
         bit           u;
         logic [W-1:0] av, bv;
         logic         sm;
         u  = 1'($urandom_range(0, 1));
         av = W'($urandom);
         sm = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0:       bv = 16'h0000;
            1:       bv = 16'h8000;
            2:       bv = W'($urandom_range(0, 255));
            default: bv = W'($urandom);
         endcase
         model(u, av, bv, sm, exp_res, exp_lat);
         run_op(u, av, bv, sm, int'($urandom_range(0, 2)), res, lat);
         chk("rand_result",  64'(res), 64'(exp_res));
         chk("rand_latency", 64'(lat), 64'(exp_lat));
      end

      // Backpressure: result held for 10 cycles, a stray in_valid is dropped.
      drive_in(1'b0, 1'b1, 16'd3, 16'd5, 1'b0);
      @(posedge clk); #1;
      drive_in(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
      lat = 0;
      while (!if_s.out_valid && lat < MAXLAT) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("bp_latency", 64'(lat), 64'(3));
      for (int c = 0; c < 10; c++) begin
         if (c == 4) drive_in(1'b0, 1'b1, 16'd7, 16'd7, 1'b0);
         @(posedge clk); #1;
         drive_in(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
         chk("bp_out_valid", 64'(if_s.out_valid), 64'(1));
         chk("bp_result",    64'(if_s.result),    64'(32'h0000000F));
         chk("bp_in_ready",  64'(if_s.in_ready),  64'(0));
      end
      set_ordy(1'b0, 1'b1);
      @(posedge clk); #1;
      set_ordy(1'b0, 1'b0);
      chk("bp_release_ready", 64'(if_s.in_ready),  64'(1));
      chk("bp_release_valid", 64'(if_s.out_valid), 64'(0));
      @(posedge clk); #1;
      chk("bp_pulse_not_queued", 64'(if_s.busy),   64'(0));
      chk("bp_result_retained",  64'(if_s.result), 64'(32'h0000000F));
      $display("op dut=signed_en backpressure sequence a=0003 b=0005 held 10 cycles");
      run_op(1'b0, 16'd2, 16'd2, 1'b0, 0, res, lat);
      chk("after_bp_result", 64'(res), 64'(32'h00000004));

      // Reset two cycles into a full-length multiply.
      drive_in(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
      @(posedge clk); #1;
      drive_in(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("pre_reset_busy", 64'(if_s.busy), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(if_s.out_valid), 64'(0));
      chk("midrst_busy",      64'(if_s.busy),      64'(0));
      chk("midrst_result",    64'(if_s.result),    64'(0));
      chk("midrst_in_ready",  64'(if_s.in_ready),  64'(1));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      $display("op dut=signed_en reset during a=ffff b=ffff multiply");
      run_op(1'b0, 16'd7, 16'd9, 1'b0, 0, res, lat);
      chk("post_reset_result",  64'(res), 64'(32'h0000003F));
      chk("post_reset_latency", 64'(lat), 64'(4));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
